// File: rtl/vc_router_pkg.sv
// Shared widths and helpers for the virtual-channel router blocks.
package vc_router_pkg;

  localparam int unsigned NUM_PORTS_DFLT = 5;
  localparam int unsigned NUM_VCS_DFLT   = 4;
  localparam int unsigned PORT_W         = $clog2(NUM_PORTS_DFLT);
  localparam int unsigned VC_W           = $clog2(NUM_VCS_DFLT);

  // Index of the highest set bit; callers only use it on a non-empty mask.
  function automatic int unsigned msb_index(input logic [31:0] mask);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (mask[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/vc_alloc_ctrl_rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting the search at the pointer,
// pointer advances past the winner only when a grant is issued.
module rr_arbiter #(
  parameter int unsigned N = 20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  input  logic                 grant_en,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] ptr
);

  localparam int unsigned PW = $clog2(N);

  logic [PW-1:0] win;
  logic          found;

  always_comb begin
    gnt   = '0;
    win   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && grant_en && req[(32'(ptr) + i) % N]) begin
        found = 1'b1;
        win   = PW'((32'(ptr) + i) % N);
      end
    end
    if (found) gnt[win] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= (32'(win) == N - 1) ? '0 : win + 1'b1;
    end
  end

endmodule

// File: rtl/vc_alloc_ctrl.sv
// Output-VC allocator: per-port round-robin over input VCs, highest free
// downstream VC to the winner, free mask maintained against releases.
module vc_alloc_ctrl
  import vc_router_pkg::msb_index;
#(
  parameter int unsigned NUM_PORTS = 5,
  parameter int unsigned NUM_VCS   = 4
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [NUM_PORTS*NUM_VCS-1:0]            req,
  input  logic [NUM_PORTS*NUM_VCS*$clog2(NUM_PORTS)-1:0] req_port,
  input  logic [NUM_PORTS-1:0]                    release_valid,
  input  logic [NUM_PORTS*$clog2(NUM_VCS)-1:0]    release_vc,
  output logic [NUM_PORTS*NUM_VCS-1:0]            grant,
  output logic [NUM_PORTS*NUM_VCS*$clog2(NUM_VCS)-1:0] grant_vc,
  output logic [NUM_PORTS*NUM_VCS-1:0]            vc_availability,
  output logic                                    err_release
);

  localparam int unsigned PORT_W = $clog2(NUM_PORTS);
  localparam int unsigned VC_W   = $clog2(NUM_VCS);
  localparam int unsigned NIVC   = NUM_PORTS * NUM_VCS;
  localparam int unsigned PTR_W  = $clog2(NIVC);

  logic [NIVC-1:0]      port_req [NUM_PORTS];
  logic [NIVC-1:0]      port_gnt [NUM_PORTS];
  logic [PTR_W-1:0]     port_ptr [NUM_PORTS];
  logic [VC_W-1:0]      top_vc   [NUM_PORTS];
  logic [NUM_PORTS-1:0] port_en;

  logic [NIVC-1:0]      grant_d, alloc_bits, release_bits, avail_d;
  logic [NIVC*VC_W-1:0] grant_vc_d;
  logic                 err_d;

  // A requester granted last cycle is masked so it cannot win twice before dropping req.
  always_comb begin
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      for (int unsigned k = 0; k < NIVC; k++) begin
        port_req[p][k] = req[k] & ~grant[k] &
                         (32'(req_port[k*PORT_W +: PORT_W]) == p);
      end
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign port_en[p] = |vc_availability[p*NUM_VCS +: NUM_VCS];
    assign top_vc[p]  = VC_W'(msb_index(32'(vc_availability[p*NUM_VCS +: NUM_VCS])));

    rr_arbiter #(.N(NIVC)) u_arb (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (port_req[p]),
      .grant_en (port_en[p]),
      .gnt      (port_gnt[p]),
      .ptr      (port_ptr[p])
    );

    always_comb assert (32'(port_ptr[p]) < NIVC);
  end

  always_comb begin
    grant_d      = '0;
    grant_vc_d   = '0;
    alloc_bits   = '0;
    release_bits = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (|port_gnt[p]) alloc_bits[p*NUM_VCS + 32'(top_vc[p])] = 1'b1;
      for (int unsigned k = 0; k < NIVC; k++) begin
        if (port_gnt[p][k]) begin
          grant_d[k]                   = 1'b1;
          grant_vc_d[k*VC_W +: VC_W]   = top_vc[p];
        end
      end
      if (release_valid[p])
        release_bits[p*NUM_VCS + 32'(release_vc[p*VC_W +: VC_W])] = 1'b1;
    end
    // Releasing a bit that is being allocated this cycle is legal; release wins.
    err_d   = |(release_bits & vc_availability & ~alloc_bits);
    avail_d = (vc_availability & ~alloc_bits) | release_bits;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant           <= '0;
      grant_vc        <= '0;
      vc_availability <= '1;
      err_release     <= 1'b0;
    end else begin
      grant           <= grant_d;
      grant_vc        <= grant_vc_d;
      vc_availability <= avail_d;
      err_release     <= err_release | err_d;
    end
  end

endmodule

// File: doc/vc_alloc_ctrl.md
# vc_alloc_ctrl

Output-VC allocation controller for the virtual-channel router. It arbitrates among all input VCs requesting a given output port and assigns each winner one free downstream VC. It keeps the per-port free-VC mask, clearing bits on allocation and setting them again when the downstream router releases a VC. It sits between route computation (which supplies the target port) and switch allocation (which consumes the granted output VC).

## Interface
Parameters:
- NUM_PORTS, 5, router ports; output port p owns mask bits [p*NUM_VCS +: NUM_VCS]
- NUM_VCS, 4, VCs per port

Derived widths:
- PORT_W = $clog2(NUM_PORTS)
- VC_W = $clog2(NUM_VCS)
- NIVC = NUM_PORTS*NUM_VCS

Ports (clock and reset first):
- clk  in  1  single clock; all state updates on posedge
- rst_n  in  1  asynchronous, active-low reset
- req  in  NIVC  input VC k requests an output VC; level, held until granted
- req_port  in  NIVC*PORT_W  target output port of input VC k, field k; valid while req[k]
- release_valid  in  NUM_PORTS  downstream frees one VC on output port p this cycle
- release_vc  in  NUM_PORTS*VC_W  VC id freed on port p, field p
- grant  out  NIVC  registered one-cycle pulse; input VC k was allocated
- grant_vc  out  NIVC*VC_W  allocated VC id for input VC k; valid when grant[k], else 0
- vc_availability  out  NIVC  registered free mask; 1 = free
- err_release  out  1  sticky; a VC that was already free was released

## Operation
- For each output port p, a round-robin arbiter considers requester k when all of the following hold:
  - req[k]
  - req_port[k]==p
  - !grant[k] (a requester granted in the previous cycle is masked)
- Port p grants only if its mask field in vc_availability is nonzero. At most one grant per port per cycle, so up to NUM_PORTS grants per cycle in total.
- The winner gets the highest-index free VC of port p. This is the first 1 from the MSB of the field.
- The round-robin pointer of port p moves to winner+1 (mod NIVC) only on a grant. With no grant, it holds.
- Mask update at each edge:
  - next = (current & ~alloc_bits) | release_bits
  - release_bits: bit p*NUM_VCS+release_vc[p] when release_valid[p]
- If a release targets a bit that is already 1 and is not being allocated that cycle:
  - the bit stays 1
  - err_release sets and stays set until reset
- req_port values ≥ NUM_PORTS never win arbitration.

## Timing
- Reset (async assert, sync-safe deassert): vc_availability all 1, grant 0, grant_vc 0, pointers 0, err_release 0.
- Latency: req is sampled at edge N. grant, grant_vc and the cleared mask bit are all visible after edge N. Granted requesters must drop req in the grant cycle.
- Arbitration in cycle N uses the registered mask. A release in cycle N is usable at the earliest in cycle N+1.
- Simultaneous allocation and release of the same bit: release wins, and the bit ends at 1. This is legal and is not an error.
- Mask empty: no grant. Requests wait with no starvation, because the pointer is preserved.
- Reset mid-operation: pending grants are lost and all VCs become free. Requesters reissue.

## Structure
Shared package vc_router_pkg holds:
- PORT_W, VC_W
- a helper function that returns the highest-set-bit index of a NUM_VCS mask

Sub-module rr_arbiter (parameter N):
- inputs: req[N], grant_en
- outputs: one-hot gnt[N], registered pointer
- instantiated once per output port with N=NIVC

The controller holds the mask register, the grant registers and the error flag.

## Test plan
- Reset, then a single request: req[0]=1, req_port[0]=2.
  - After 1 edge: grant[0]=1 and grant_vc[0]=3.
  - vc_availability[11:8]=4'b0111.
- Exhaustion: 5 requesters all target port 1.
  - Grants go to VCs 3,2,1,0 on successive cycles.
  - The 5th requester waits with mask 0.
  - release_vc[1]=2 → 5th requester gets grant_vc=2 two cycles later.
- Fairness: requesters 0, 4 and 8 hold req to port 0 with releases every cycle.
  - Grant order is 0, 4, 8, 0, with no repeats before rotation.
- Parallel: requesters 0→port 0 and 5→port 3 in the same cycle.
  - Both are granted in the same cycle with grant_vc=3.
- Same-cycle allocate and release of port 2 VC 3 → the bit stays 1 and err_release stays 0.
- Releasing a free VC sets err_release.
- Asserting rst_n=0 mid-traffic clears grant immediately and restores all-ones.
